loopback_err_scan_ctrl: RTL and testbench

LOOPBACK_ERR_SCAN_CTRL -- requirements
Module: loopback_err_scan_ctrl

---
 rtl/loopback_err_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_loopback_err_scan_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_err_scan_ctrl.sv
// Per-lane loopback error counters with a round-robin snapshot scanner
// that presents one lane's count word at a time to a software register.
module loopback_err_scan_ctrl #(
    parameter int unsigned DWELL   = 1024,
    parameter int unsigned N_LANES = 4
) (
    input  logic               OPB_Clk,
    input  logic               OPB_Rst,
    input  logic [N_LANES-1:0] lane_err,
    input  logic [N_LANES-1:0] lane_enable,
    input  logic               clr_req,
    input  logic               freeze,
    output logic [31:0]        user_data_out,
    output logic [1:0]         cur_lane,
    output logic               scan_wrap,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    localparam logic [28:0] CMAX     = '1;
    localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);

    logic [N_LANES-1:0][28:0] cnt_q, cnt_d;
    logic [N_LANES-1:0]       sat_q, sat_d;

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [15:0] dwell_q;
    logic [31:0] word_q;
    logic [1:0]  lane_q;
    logic        wrap_q;
    logic        loaded_q;

    logic [1:0]  nxt_incl, nxt_excl;
    logic [1:0]  ia, ib;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        for (int i = 0; i < N_LANES; i++) begin
            if (clr_req) begin
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end else if (lane_err[i] && lane_enable[i] && cnt_q[i] != CMAX) begin
                cnt_d[i] = cnt_q[i] + 29'd1;
                if (cnt_q[i] == CMAX - 29'd1) sat_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            cnt_q <= '0;
            sat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    // Descending scan so the closest enabled lane is the last one written.
    always_comb begin
        nxt_incl = ptr_q;
        nxt_excl = ptr_q;
        ia = ptr_q;
        ib = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            ia = ptr_q + k[1:0];
            ib = ptr_q + k[1:0] + 2'd1;
            if (lane_enable[ia]) nxt_incl = ia;
            if (lane_enable[ib]) nxt_excl = ib;
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            dwell_q  <= '0;
            word_q   <= '0;
            lane_q   <= '0;
            wrap_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|lane_enable) begin
                        ptr_q   <= nxt_incl;
                        wrap_q  <= loaded_q && (nxt_incl <= lane_q);
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    word_q   <= {ptr_q, sat_q[ptr_q], cnt_q[ptr_q]};
                    lane_q   <= ptr_q;
                    loaded_q <= 1'b1;
                    dwell_q  <= DWELL_M1;
                    state_q  <= HOLD;
                end
                HOLD: begin
                    if (!freeze) begin
                        if (dwell_q == 16'd0) begin
                            if (|lane_enable) begin
                                ptr_q   <= nxt_excl;
                                wrap_q  <= loaded_q && (nxt_excl <= lane_q);
                                state_q <= LOAD;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            dwell_q <= dwell_q - 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign user_data_out = word_q;
    assign cur_lane      = lane_q;
    assign scan_wrap     = wrap_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_loopback_err_scan_ctrl.sv
// Scenario bench for loopback_err_scan_ctrl with DWELL=4 (5-cycle lane period);
// expected snapshot words are queued as stimulus is applied and popped at each load.
module tb_loopback_err_scan_ctrl;

    typedef struct packed {
        logic [31:0] word;
        logic        wrap;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  lane_err;
    logic [3:0]  lane_enable;
    logic        clr_req;
    logic        freeze;
    logic [31:0] user_data_out;
    logic [1:0]  cur_lane;
    logic        scan_wrap;
    logic        busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    loopback_err_scan_ctrl #(.DWELL(4), .N_LANES(4)) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .lane_err     (lane_err),
        .lane_enable  (lane_enable),
        .clr_req      (clr_req),
        .freeze       (freeze),
        .user_data_out(user_data_out),
        .cur_lane     (cur_lane),
        .scan_wrap    (scan_wrap),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic [3:0] en);
        @(negedge clk);
        rst = 1'b1;
        lane_err = '0;
        clr_req = 1'b0;
        freeze = 1'b0;
        lane_enable = en;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lane_enable = 4'hF;
        lane_err = 4'hF;
        repeat (3) @(negedge clk);
        total++;
        if (user_data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_udo: got %h want %h", user_data_out, 32'h0);
        end
        total++;
        if (cur_lane !== 2'd0) begin
            bad++;
            $display("FAIL reset_lane: got %0d want 0", cur_lane);
        end
        total++;
        if (scan_wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_wrap: got %b want 0", scan_wrap);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_scan();
        exp_t cur;
        do_reset(4'hF);
        lane_err = 4'b0100;
        sb.push_back({32'h0000_0000, 1'b0});
        sb.push_back({32'h4000_0000, 1'b0});
        sb.push_back({32'h8000_0003, 1'b0});
        sb.push_back({32'hC000_0000, 1'b0});
        sb.push_back({32'h0000_0000, 1'b1});
        cur = '0;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (n == 3) lane_err = 4'b0;
            if (n == 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL scan_busy: got %b want 1", busy);
                end
            end
            if ((n - 1) % 5 == 0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL scan_sb: got empty want entry");
                end else if (scan_wrap !== sb[0].wrap) begin
                    bad++;
                    $display("FAIL scan_wrap n=%0d: got %b want %b", n, scan_wrap, sb[0].wrap);
                end
            end
            if (n >= 2 && (n - 2) % 5 == 0 && sb.size() != 0) begin
                cur = sb.pop_front();
                total++;
                if (user_data_out !== cur.word) begin
                    bad++;
                    $display("FAIL scan_word n=%0d: got %h want %h", n, user_data_out, cur.word);
                end
                total++;
                if (cur_lane !== cur.word[31:30]) begin
                    bad++;
                    $display("FAIL scan_lane n=%0d: got %0d want %0d", n, cur_lane, cur.word[31:30]);
                end
            end
            if (n >= 2 && (n - 2) % 5 == 4) begin
                total++;
                if (user_data_out !== cur.word) begin
                    bad++;
                    $display("FAIL scan_stable n=%0d: got %h want %h", n, user_data_out, cur.word);
                end
            end
        end
    endtask

    task automatic test_mask();
        exp_t cur;
        do_reset(4'b1010);
        sb.push_back({32'h4000_0000, 1'b0});
        sb.push_back({32'hC000_0000, 1'b0});
        sb.push_back({32'h4000_0000, 1'b1});
        sb.push_back({32'hC000_0000, 1'b0});
        sb.push_back({32'h4000_0000, 1'b1});
        cur = '0;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if ((n - 1) % 5 == 0 && sb.size() != 0) begin
                total++;
                if (scan_wrap !== sb[0].wrap) begin
                    bad++;
                    $display("FAIL mask_wrap n=%0d: got %b want %b", n, scan_wrap, sb[0].wrap);
                end
            end
            if (n >= 2 && (n - 2) % 5 == 0 && sb.size() != 0) begin
                cur = sb.pop_front();
                total++;
                if (cur_lane !== cur.word[31:30] || user_data_out !== cur.word) begin
                    bad++;
                    $display("FAIL mask_load n=%0d: got %h/%0d want %h/%0d", n,
                             user_data_out, cur_lane, cur.word, cur.word[31:30]);
                end
            end
        end
    endtask

    task automatic test_sat();
        exp_t cur;
        do_reset(4'h1);
        force dut.cnt_q = {29'd0, 29'd0, 29'd0, 29'h1FFF_FFFE};
        #1;
        release dut.cnt_q;
        lane_err = 4'b0001;
        sb.push_back({32'h3FFF_FFFF, 1'b0});
        sb.push_back({32'h3FFF_FFFF, 1'b1});
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 2) lane_err = 4'b0;
            if ((n - 1) % 5 == 0 && sb.size() != 0) begin
                total++;
                if (scan_wrap !== sb[0].wrap) begin
                    bad++;
                    $display("FAIL sat_wrap n=%0d: got %b want %b", n, scan_wrap, sb[0].wrap);
                end
            end
            if (n >= 2 && (n - 2) % 5 == 0 && sb.size() != 0) begin
                cur = sb.pop_front();
                total++;
                if (user_data_out !== cur.word) begin
                    bad++;
                    $display("FAIL sat_word n=%0d: got %h want %h", n, user_data_out, cur.word);
                end
            end
            if (n == 8) begin
                clr_req = 1'b1;
                lane_err = 4'b0001;
                sb.push_back({32'h0000_0000, 1'b1});
            end
            if (n == 9) begin
                clr_req = 1'b0;
                lane_err = 4'b0;
            end
        end
    endtask

    task automatic test_freeze();
        exp_t cur;
        do_reset(4'hF);
        sb.push_back({32'h0000_0000, 1'b0});
        cur = '0;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 2 && sb.size() != 0) begin
                cur = sb.pop_front();
                total++;
                if (user_data_out !== cur.word) begin
                    bad++;
                    $display("FAIL frz_first: got %h want %h", user_data_out, cur.word);
                end
            end
            if (n == 3) begin
                freeze = 1'b1;
                lane_err = 4'b0010;
                sb.push_back({32'h4000_000A, 1'b0});
            end
            if (n == 8) begin
                total++;
                if (user_data_out !== cur.word || cur_lane !== 2'd0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL frz_hold: got %h/%0d/%b want %h/0/1",
                             user_data_out, cur_lane, busy, cur.word);
                end
            end
            if (n == 13) begin
                freeze = 1'b0;
                lane_err = 4'b0;
            end
            if (n == 16) begin
                total++;
                if (user_data_out !== cur.word) begin
                    bad++;
                    $display("FAIL frz_extend: got %h want %h", user_data_out, cur.word);
                end
                total++;
                if (sb.size() != 0 && scan_wrap !== sb[0].wrap) begin
                    bad++;
                    $display("FAIL frz_wrap: got %b want %b", scan_wrap, sb[0].wrap);
                end
            end
            if (n == 17 && sb.size() != 0) begin
                cur = sb.pop_front();
                total++;
                if (user_data_out !== cur.word || cur_lane !== 2'd1) begin
                    bad++;
                    $display("FAIL frz_next: got %h/%0d want %h/1", user_data_out, cur_lane, cur.word);
                end
            end
        end
    endtask

    task automatic test_idle_rst();
        exp_t cur;
        do_reset(4'h3);
        lane_err = 4'b0001;
        sb.push_back({32'h0000_0001, 1'b0});
        cur = '0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) lane_err = 4'b0;
            if ((n == 2 || n == 10 || n == 14) && sb.size() != 0) begin
                cur = sb.pop_front();
                total++;
                if (user_data_out !== cur.word || cur_lane !== cur.word[31:30]) begin
                    bad++;
                    $display("FAIL idle_load n=%0d: got %h/%0d want %h/%0d", n,
                             user_data_out, cur_lane, cur.word, cur.word[31:30]);
                end
            end
            if (n == 3) lane_enable = 4'b0;
            if (n == 6 || n == 8) begin
                total++;
                if (busy !== 1'b0 || user_data_out !== cur.word || cur_lane !== 2'd0) begin
                    bad++;
                    $display("FAIL idle_keep n=%0d: got %b/%h/%0d want 0/%h/0", n,
                             busy, user_data_out, cur_lane, cur.word);
                end
            end
            if (n == 8) begin
                lane_enable = 4'b0010;
                sb.push_back({32'h4000_0000, 1'b0});
            end
            if (n == 9) begin
                total++;
                if (busy !== 1'b1 || (sb.size() != 0 && scan_wrap !== sb[0].wrap)) begin
                    bad++;
                    $display("FAIL idle_wake: got %b/%b want 1/0", busy, scan_wrap);
                end
            end
            if (n == 11) begin
                rst = 1'b1;
                #1;
                total++;
                if (user_data_out !== 32'h0 || cur_lane !== 2'd0 ||
                    busy !== 1'b0 || scan_wrap !== 1'b0) begin
                    bad++;
                    $display("FAIL async_rst: got %h/%0d/%b/%b want 0/0/0/0",
                             user_data_out, cur_lane, busy, scan_wrap);
                end
                sb.push_back({32'h4000_0000, 1'b0});
            end
            if (n == 12) rst = 1'b0;
            if (n == 13) begin
                total++;
                if (user_data_out !== 32'h0 || busy !== 1'b1 || scan_wrap !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_release: got %h/%b/%b want 0/1/0",
                             user_data_out, busy, scan_wrap);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        lane_err = '0;
        lane_enable = '0;
        clr_req = 1'b0;
        freeze = 1'b0;
        test_reset();
        test_scan();
        test_mask();
        test_sat();
        test_freeze();
        test_idle_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
